mod_updown_counter: RTL and testbench
=====================================

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, as the counter width in bits (legal range 2..32).
REQ-002 The block SHALL take parameter MODULUS, default 256, as the count range 0..MODULUS-1 (legal range 2..2^WIDTH).
REQ-003 The block SHALL take parameter PRESCALE, default 1, as the number of enabled clk cycles per count step (legal range 1..65535).
REQ-004 The block SHALL take parameter SATURATE, default 0: 0 = wrap at the limits, 1 = hold at the limits.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port en, input, 1 bit: count enable; it advances the prescaler.
REQ-008 The block SHALL have port up_dn, input, 1 bit: 1 = count up, 0 = count down, sampled on each step.
REQ-009 The block SHALL have port load, input, 1 bit: synchronous load request.
REQ-010 The block SHALL have port load_val, input, WIDTH bits: the load value.
REQ-011 The block SHALL have port clear, input, 1 bit: synchronous clear of the count, the prescaler and ovf.
REQ-012 The block SHALL have port q, output, WIDTH bits: the registered count.
REQ-013 The block SHALL have port tc, output, 1 bit: registered one-cycle terminal-count pulse.
REQ-014 The block SHALL have port ovf, output, 1 bit: sticky boundary-crossing flag.

Function
REQ-015 Per-cycle priority SHALL be rst > clear > load > step > hold.
REQ-016 The prescaler SHALL count 0..PRESCALE-1 on en=1 cycles; it generates a step on the cycle it is at PRESCALE-1 with en=1, then returns to 0.
REQ-017 The prescaler SHALL hold its value when en=0.
REQ-018 With PRESCALE=1, every en=1 cycle SHALL be a step.
REQ-019 Clear or load SHALL zero the prescaler.
REQ-020 On a step with up_dn=1, q SHALL become q+1; at q=MODULUS-1 it becomes 0 (wrap) or stays at MODULUS-1 (SATURATE=1).
REQ-021 On a step with up_dn=0, q SHALL become q-1; at q=0 it becomes MODULUS-1 (wrap) or stays at 0 (SATURATE=1).
REQ-022 tc SHALL be 1 in the cycle after a step taken from the boundary value in the step direction (MODULUS-1 up, 0 down), in both wrap and saturate modes, and 0 otherwise.
REQ-023 ovf SHALL set on the same edge that tc is set, and remain set until rst or clear.
REQ-024 On load, q SHALL take load_val; a load_val of MODULUS or more SHALL be clamped to MODULUS-1.
REQ-025 A load SHALL suppress any step, tc and ovf update in that cycle.
REQ-026 On clear, q SHALL become 0, ovf 0 and tc 0.
REQ-027 Count arithmetic SHALL be WIDTH bits wide and never let q leave 0..MODULUS-1.
REQ-028 A change of up_dn between steps SHALL take effect on the next step, with no extra latency.

Reset
REQ-029 While rst=1 at a clk edge, q, the prescaler, tc and ovf SHALL all become 0, regardless of the other inputs.
REQ-030 An rst in the middle of a prescale period SHALL discard the partial period; the first step after rst then needs PRESCALE fresh en=1 cycles.

Structure
REQ-031 The shared package/header SHALL hold the SATURATE mode encodings (MODE_WRAP=0, MODE_SAT=1) and a clog2 helper for sizing the prescaler.
REQ-032 The prescaler SHALL be a separate sub-module, tick_prescaler (params PRESCALE; ports clk, rst, en, clr, tick), instantiated once.
REQ-033 All outputs SHALL be driven directly from flops, with no combinational paths from input to output.

Verification
REQ-034 Wrap up (defaults): rst, then en=1, up_dn=1 for 256 cycles -> q goes 0..255 then 0; tc=1 for exactly one cycle, the cycle after the 255->0 step; ovf=1 afterwards.
REQ-035 Down and saturate (MODULUS=10, SATURATE=1): load 2, down for 4 steps -> q 1,0,0,0; tc pulses on each step taken at 0; ovf=1.
REQ-036 Prescale (PRESCALE=3): en=1 for 9 cycles with one en=0 inserted -> q increments exactly 3 times, the paused cycle adding no count.
REQ-037 Load clamp and priority (MODULUS=10): load=1, load_val=15, en=1 -> q=9 with no step; clear and load in the same cycle -> q=0.
REQ-038 Mid-operation reset (PRESCALE=4, q=5, prescaler at 2): rst for one cycle -> q=0, ovf=0, tc=0; next step after 4 en=1 cycles gives q=1.

Source files
------------

// File: rtl/mod_updown_counter_pkg.sv
// Shared definitions for the up/down counter: saturation mode encodings and
// a ceiling-log2 helper used to size the prescaler register.
package mod_updown_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Smallest n with 2**n >= value; returns 0 for value <= 1.
  function automatic int clog2(input longint value);
    int result;
    result = 0;
    for (int i = 0; i < 63; i++) begin
      if ((64'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/mod_updown_counter_tick_prescaler.sv
// Prescaler: counts enabled cycles 0..PRESCALE-1 and flags the enabled cycle
// on which it sits at PRESCALE-1 as a tick.
module tick_prescaler
  import mod_updown_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_r;
  logic          at_last_s;

  assign at_last_s = (cnt_r == LAST);
  // The tick is combinational so the step lands on the same edge that wraps the prescaler.
  assign tick      = en & at_last_s;

  // Prescale counter; clr discards any partial period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {PW{1'b0}};
    end else if (clr) begin
      cnt_r <= {PW{1'b0}};
    end else if (en) begin
      if (at_last_s) begin
        cnt_r <= {PW{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(PW-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Prescaled up/down modulo counter with load, clear, terminal-count pulse and
// a sticky overflow flag; wraps or saturates at the count limits.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = 256,
  parameter int     PRESCALE = 1,
  parameter int     SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULUS - 64'sd1);
  localparam logic [WIDTH-1:0] ZERO_Q = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_Q  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_r;
  logic             tc_r;
  logic             ovf_r;
  logic             tick_s;
  logic             at_bound_s;
  logic [WIDTH-1:0] step_q_s;
  logic [WIDTH-1:0] load_q_s;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (clear | load),
    .tick(tick_s)
  );

  // Next count for a step in the current direction, honouring wrap/saturate.
  always_comb begin
    step_q_s   = q_r;
    at_bound_s = 1'b0;
    if (up_dn) begin
      at_bound_s = (q_r == MAX_Q);
      if (at_bound_s) begin
        step_q_s = (SATURATE == MODE_SAT) ? MAX_Q : ZERO_Q;
      end else begin
        step_q_s = q_r + ONE_Q;
      end
    end else begin
      at_bound_s = (q_r == ZERO_Q);
      if (at_bound_s) begin
        step_q_s = (SATURATE == MODE_SAT) ? ZERO_Q : MAX_Q;
      end else begin
        step_q_s = q_r - ONE_Q;
      end
    end
  end

  // Out-of-range load values are clamped to the top of the count range.
  always_comb begin
    if (load_val > MAX_Q) begin
      load_q_s = MAX_Q;
    end else begin
      load_q_s = load_val;
    end
  end

  // Count, terminal-count and overflow registers; priority rst > clear > load > step.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r   <= ZERO_Q;
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else if (clear) begin
      q_r   <= ZERO_Q;
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else if (load) begin
      q_r   <= load_q_s;
      tc_r  <= 1'b0;
      ovf_r <= ovf_r;
    end else if (tick_s) begin
      q_r   <= step_q_s;
      tc_r  <= at_bound_s;
      ovf_r <= ovf_r | at_bound_s;
    end else begin
      q_r   <= q_r;
      tc_r  <= 1'b0;
      ovf_r <= ovf_r;
    end
  end

  assign q   = q_r;
  assign tc  = tc_r;
  assign ovf = ovf_r;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter: four parameterisations driven one at
// a time by directed vectors; a negedge monitor pops and checks expectations.
module tb_mod_updown_counter;

  typedef struct {
    int         idx;
    logic [7:0] q;
    logic       tc;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst_v   [4];
  logic       en_v    [4];
  logic       up_v    [4];
  logic       load_v  [4];
  logic [7:0] lval_v  [4];
  logic       clear_v [4];
  logic [7:0] q_o     [4];
  logic       tc_o    [4];
  logic       ovf_o   [4];

  exp_t sbq[$];
  int   n_tests;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: defaults (wrap, 256)
  mod_updown_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(1), .SATURATE(0)) u0 (
    .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .up_dn(up_v[0]), .load(load_v[0]),
    .load_val(lval_v[0]), .clear(clear_v[0]), .q(q_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]));
  // 1: modulus 10, saturate
  mod_updown_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u1 (
    .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .up_dn(up_v[1]), .load(load_v[1]),
    .load_val(lval_v[1]), .clear(clear_v[1]), .q(q_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]));
  // 2: prescale 3
  mod_updown_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(3), .SATURATE(0)) u2 (
    .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .up_dn(up_v[2]), .load(load_v[2]),
    .load_val(lval_v[2]), .clear(clear_v[2]), .q(q_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]));
  // 3: prescale 4
  mod_updown_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(4), .SATURATE(0)) u3 (
    .clk(clk), .rst(rst_v[3]), .en(en_v[3]), .up_dn(up_v[3]), .load(load_v[3]),
    .load_val(lval_v[3]), .clear(clear_v[3]), .q(q_o[3]), .tc(tc_o[3]), .ovf(ovf_o[3]));

  // Apply one cycle of inputs to DUT i and queue the state expected after the edge.
  task automatic drive(input int i, input logic r, input logic c, input logic l,
                       input logic [7:0] lv, input logic e, input logic u,
                       input logic [7:0] eq, input logic etc, input logic eovf);
    exp_t x;
    rst_v[i]   = r;
    clear_v[i] = c;
    load_v[i]  = l;
    lval_v[i]  = lv;
    en_v[i]    = e;
    up_v[i]    = u;
    @(posedge clk);
    x.idx = i;
    x.q   = eq;
    x.tc  = etc;
    x.ovf = eovf;
    sbq.push_back(x);
    #1;
    rst_v[i]   = 1'b0;
    clear_v[i] = 1'b0;
    load_v[i]  = 1'b0;
    en_v[i]    = 1'b0;
  endtask

  // Monitor: one expectation per cycle, compared away from the active edge.
  always @(negedge clk) begin
    exp_t x;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      n_tests++;
      if (q_o[x.idx] !== x.q || tc_o[x.idx] !== x.tc || ovf_o[x.idx] !== x.ovf) begin
        n_fail++;
        $display("FAIL dut%0d test%0d: got q=%0d tc=%b ovf=%b, expected q=%0d tc=%b ovf=%b",
                 x.idx, n_tests, q_o[x.idx], tc_o[x.idx], ovf_o[x.idx], x.q, x.tc, x.ovf);
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 4; i++) begin
      rst_v[i] = 1'b0; en_v[i] = 1'b0; up_v[i] = 1'b0;
      load_v[i] = 1'b0; lval_v[i] = 8'd0; clear_v[i] = 1'b0;
    end
    #1;

    // Wrap up on defaults: 256 steps return to 0 with a single tc pulse.
    drive(0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 255; k++) begin
      drive(0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'(k), 1'b0, 1'b0);
    end
    drive(0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1);
    drive(0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);

    // Down with saturation at modulus 10.
    drive(1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1);
    drive(1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1);
    drive(1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    // Direction change takes effect on the very next step; load keeps ovf.
    drive(1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b1);
    drive(1, 1'b0, 1'b0, 1'b1, 8'd9, 1'b0, 1'b1, 8'd9, 1'b0, 1'b1);
    drive(1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd9, 1'b1, 1'b1);
    // Clear, then clamped load with en=1 (no step), then clear beats load.
    drive(1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b1, 8'd15, 1'b1, 1'b1, 8'd9, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd8, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b1, 8'd10, 1'b0, 1'b1, 8'd9, 1'b0, 1'b0);

    // Prescale 3: nine enabled cycles with one pause give three steps.
    drive(2, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
    drive(2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    drive(2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    drive(2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
    drive(2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
    drive(2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
    drive(2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
    drive(2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0);
    drive(2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0);
    drive(2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0);
    drive(2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0);

    // Prescale 4: wrap down sets ovf, then reset mid-period discards progress.
    drive(3, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    drive(3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    drive(3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    drive(3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    drive(3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd255, 1'b1, 1'b1);
    drive(3, 1'b0, 1'b0, 1'b1, 8'd5, 1'b1, 1'b1, 8'd5, 1'b0, 1'b1);
    drive(3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd5, 1'b0, 1'b1);
    drive(3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd5, 1'b0, 1'b1);
    drive(3, 1'b1, 1'b1, 1'b1, 8'd7, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    drive(3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    drive(3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    drive(3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    drive(3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0);

    // Let the monitor drain the scoreboard within a bounded number of cycles.
    for (int w = 0; w < 10 && sbq.size() > 0; w++) begin
      @(negedge clk);
    end
    @(posedge clk);
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
